// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, bit-position constants, the
// injection FSM state type, the FIFO entry layout and the encode function.
// The encode function is also the golden model for the decoder bench.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    // Parity bit positions within code[7:1]
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;

    // Data bit positions: d1..d4
    localparam int D1_POS = 3;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int D4_POS = 7;

    typedef enum logic {
        INJ_IDLE  = 1'b0,
        INJ_ARMED = 1'b1
    } inj_state_t;

    typedef struct packed {
        logic [CODE_W:1] code;
        logic            parity_type;
        logic            injected;
    } fifo_entry_t;

    // parity_type = 1 selects odd parity, which inverts every parity bit
    function automatic logic [CODE_W:1] hamming_encode(input logic [DATA_W:1] data,
                                                       input logic            parity_type);
        logic [CODE_W:1] c;
        c         = '0;
        c[D1_POS] = data[1];
        c[D2_POS] = data[2];
        c[D3_POS] = data[3];
        c[D4_POS] = data[4];
        c[P1]     = c[3] ^ c[5] ^ c[7] ^ parity_type;
        c[P2]     = c[3] ^ c[6] ^ c[7] ^ parity_type;
        c[P4]     = c[5] ^ c[6] ^ c[7] ^ parity_type;
        return c;
    endfunction

endpackage

// File: rtl/hamming_stream_encoder_if.sv
// Handshake bundle of the streaming encoder.
//   input side : in_valid/in_ready, in_data[4:1], in_parity_type
//   output side: out_valid/out_ready, out_code[7:1], out_parity_type, out_injected
//   injection  : inj_arm, inj_pos[2:0]
//   status     : words_sent[CNT_W-1:0]
// master = the environment driving words in and taking codewords out,
// slave  = the encoder.
interface hamming_stream_encoder_if
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W:1]   in_data;
    logic              in_parity_type;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W:1]   out_code;
    logic              out_parity_type;
    logic              out_injected;
    logic              inj_arm;
    logic [2:0]        inj_pos;
    logic [CNT_W-1:0]  words_sent;

    modport master (
        output in_valid, in_data, in_parity_type, out_ready, inj_arm, inj_pos,
        input  in_ready, out_valid, out_code, out_parity_type, out_injected, words_sent
    );

    modport slave (
        input  in_valid, in_data, in_parity_type, out_ready, inj_arm, inj_pos,
        output in_ready, out_valid, out_code, out_parity_type, out_injected, words_sent
    );

endinterface

// File: rtl/hamming_code_encoder.sv
// Combinational Hamming(7,4) encoder.
//   data_i[4:1]    data bits d4..d1
//   parity_type_i  0 = even, 1 = odd
//   code_o[7:1]    codeword, bit index = code position
module hamming_code_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W:1] data_i,
    input  logic            parity_type_i,
    output logic [CODE_W:1] code_o
);

    assign code_o = hamming_encode(data_i, parity_type_i);

endmodule

// File: rtl/hamming_stream_encoder.sv
// Streaming Hamming(7,4) encoder: encodes accepted words, buffers them in a
// DEPTH-entry FIFO and presents them downstream; supports one-shot single-bit
// error injection and counts completed output handshakes.
//   clk, rst : clock and synchronous active-high reset
//   bus      : hamming_stream_encoder_if.slave (handshakes, injection, counter)
//
// Injection FSM
//   state     | meaning
//   INJ_IDLE  | no corruption pending
//   INJ_ARMED | next word accepted (not in an arming cycle) gets code[pos] flipped
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    hamming_stream_encoder_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;
    fifo_entry_t      mem_q [DEPTH];

    inj_state_t       inj_state_q;
    logic [2:0]       inj_pos_q;

    logic             full, empty, push, pop, arm_req, inject;
    logic [CODE_W:1]  enc_code, flip_mask;
    fifo_entry_t      wr_entry, head;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_valid & bus.out_ready;

    // An arm in the same cycle as an accept takes precedence: that word stays clean
    assign arm_req = bus.inj_arm & (bus.inj_pos != 3'd0);
    assign inject  = (inj_state_q == INJ_ARMED) & push & ~arm_req;

    hamming_code_encoder u_enc (
        .data_i        (bus.in_data),
        .parity_type_i (bus.in_parity_type),
        .code_o        (enc_code)
    );

    always_comb begin
        flip_mask = '0;
        for (int i = 1; i <= CODE_W; i++) begin
            if (inject && (inj_pos_q == 3'(i))) begin
                flip_mask[i] = 1'b1;
            end
        end
    end

    assign wr_entry.code        = enc_code ^ flip_mask;
    assign wr_entry.parity_type = bus.in_parity_type;
    assign wr_entry.injected    = inject;

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        words_sent_d = pop  ? words_sent_q + CNT_W'(1) : words_sent_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            words_sent_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Storage needs no reset; clearing the pointers discards its contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_state_q <= INJ_IDLE;
            inj_pos_q   <= 3'd0;
        end else if (arm_req) begin
            inj_state_q <= INJ_ARMED;
            inj_pos_q   <= bus.inj_pos;
        end else if (inject) begin
            inj_state_q <= INJ_IDLE;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Outputs read as zero while empty so stale storage never shows
    assign bus.in_ready        = ~full;
    assign bus.out_valid       = ~empty;
    assign bus.out_code        = empty ? '0   : head.code;
    assign bus.out_parity_type = empty ? 1'b0 : head.parity_type;
    assign bus.out_injected    = empty ? 1'b0 : head.injected;
    assign bus.words_sent      = words_sent_q;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
module tb_hamming_stream_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_stream_encoder_if #(.CNT_W(CNT_W)) bus ();

    hamming_stream_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:1] code;
        logic       pt;
        logic       inj;
    } exp_t;

    exp_t       mq[$];
    logic       m_armed = 1'b0;
    logic [2:0] m_pos   = 3'd0;
    int         m_sent  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Generic Hamming rule: parity bit at position p covers every position j with (j & p) != 0
    function automatic logic [7:1] ref_enc(input logic [3:0] d, input logic pt);
        int dpos[4] = '{3, 5, 6, 7};
        int ppos[3] = '{1, 2, 4};
        logic [7:1] c = '0;
        logic par;
        for (int i = 0; i < 4; i++) c[dpos[i]] = d[i];
        for (int k = 0; k < 3; k++) begin
            par = pt;
            for (int j = 1; j <= 7; j++)
                if (j != ppos[k] && (j & ppos[k]) != 0) par ^= c[j];
            c[ppos[k]] = par;
        end
        return c;
    endfunction

    task automatic model_step();
        exp_t e;
        int   sz;
        logic m_push, m_pop, arm_ok, inj;
        if (rst) begin
            mq.delete();
            m_armed = 1'b0;
            m_pos   = 3'd0;
            m_sent  = 0;
            return;
        end
        sz     = mq.size();
        m_push = bus.in_valid && (sz < DEPTH);
        m_pop  = (sz > 0) && bus.out_ready;
        arm_ok = bus.inj_arm && (bus.inj_pos != 3'd0);
        inj    = m_push && m_armed && !arm_ok;
        if (m_pop) begin
            void'(mq.pop_front());
            m_sent = (m_sent + 1) % (1 << CNT_W);
        end
        if (m_push) begin
            e.code = ref_enc(bus.in_data, bus.in_parity_type);
            if (inj) e.code[m_pos] = ~e.code[m_pos];
            e.pt  = bus.in_parity_type;
            e.inj = inj;
            mq.push_back(e);
        end
        if (arm_ok) begin
            m_armed = 1'b1;
            m_pos   = bus.inj_pos;
        end else if (inj) begin
            m_armed = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("out_valid", bus.out_valid, mq.size() > 0);
            chk("in_ready", bus.in_ready, mq.size() < DEPTH);
            if (mq.size() > 0) begin
                chk("out_code", bus.out_code, mq[0].code);
                chk("out_parity_type", bus.out_parity_type, mq[0].pt);
                chk("out_injected", bus.out_injected, mq[0].inj);
            end else begin
                chk("out_code_empty", bus.out_code, 0);
                chk("out_parity_type_empty", bus.out_parity_type, 0);
                chk("out_injected_empty", bus.out_injected, 0);
            end
            chk("words_sent", bus.words_sent, m_sent);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.inj_arm  = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Assumes an empty FIFO and out_ready = 1
    task automatic push_and_check(input logic [3:0] d, input logic pt,
                                  input logic [7:1] exp_code, input logic exp_inj,
                                  input string nm);
        bus.in_valid       = 1'b1;
        bus.in_data        = d;
        bus.in_parity_type = pt;
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_code"}, bus.out_code, exp_code);
        chk({nm, "_inj"}, bus.out_injected, exp_inj);
        cyc();
    endtask

    logic [3:0] w[5] = '{4'h1, 4'h6, 4'h9, 4'hE, 4'h3};

    initial begin
        int idx;
        logic deassert;

        bus.in_valid       = 1'b0;
        bus.in_data        = 4'h0;
        bus.in_parity_type = 1'b0;
        bus.out_ready      = 1'b0;
        bus.inj_arm        = 1'b0;
        bus.inj_pos        = 3'd0;

        chk("pin_even_1011", ref_enc(4'b1011, 1'b0), 7'b1010101);
        chk("pin_odd_1011", ref_enc(4'b1011, 1'b1), 7'b1011110);
        chk("pin_odd_0000", ref_enc(4'b0000, 1'b1), 7'b0001011);

        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_code", bus.out_code, 0);
        chk("rst_words_sent", bus.words_sent, 0);
        cyc();

        bus.out_ready = 1'b1;
        push_and_check(4'b1011, 1'b0, 7'b1010101, 1'b0, "even_1011");
        @(negedge clk);
        chk("even_words_sent", bus.words_sent, 1);
        cyc();
        push_and_check(4'b1011, 1'b1, 7'b1011110, 1'b0, "odd_1011");
        push_and_check(4'b0000, 1'b1, 7'b0001011, 1'b0, "odd_0000");

        bus.inj_arm = 1'b1;
        bus.inj_pos = 3'd3;
        cyc();
        bus.inj_arm = 1'b0;
        push_and_check(4'b1011, 1'b0, 7'b1010001, 1'b1, "inj_pos3");
        push_and_check(4'b1011, 1'b0, 7'b1010101, 1'b0, "after_inj_clean");

        bus.inj_arm        = 1'b1;
        bus.inj_pos        = 3'd5;
        bus.in_valid       = 1'b1;
        bus.in_data        = 4'b1011;
        bus.in_parity_type = 1'b0;
        cyc();
        bus.inj_arm  = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("arm_cycle_code", bus.out_code, 7'b1010101);
        chk("arm_cycle_inj", bus.out_injected, 0);
        cyc();
        push_and_check(4'b1011, 1'b0, 7'b1000101, 1'b1, "inj_pos5");

        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[k];
            cyc();
        end
        bus.in_data = w[4];
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_head", bus.out_code, ref_enc(w[0], 1'b0));
        cyc();
        cyc();
        @(negedge clk);
        chk("full_hold_in_ready", bus.in_ready, 0);
        chk("full_hold_head", bus.out_code, ref_enc(w[0], 1'b0));
        cyc();
        bus.out_ready = 1'b1;
        idx = 0;
        deassert = 1'b0;
        for (int t = 0; t < 30 && idx < 5; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("bp_order", bus.out_code, ref_enc(w[idx], 1'b0));
                idx++;
            end
            if (bus.in_valid && bus.in_ready) deassert = 1'b1;
            cyc();
            if (deassert) bus.in_valid = 1'b0;
        end
        chk("bp_count", idx, 5);
        @(negedge clk);
        chk("bp_words_sent", bus.words_sent, 5);
        cyc();

        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[k];
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.inj_arm  = 1'b1;
        bus.inj_pos  = 3'd2;
        cyc();
        bus.inj_arm = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_words_sent", bus.words_sent, 0);
        cyc();
        bus.out_ready = 1'b1;
        push_and_check(4'b1011, 1'b0, 7'b1010101, 1'b0, "post_rst_clean");

        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.in_valid       = 1'b1;
            bus.in_data        = 4'($urandom);
            bus.in_parity_type = 1'($urandom);
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("wrap_out_valid", bus.out_valid, 0);
        chk("wrap_words_sent", bus.words_sent, 1);
        cyc();

        for (int t = 0; t < 3000; t++) begin
            rst                = ($urandom_range(0, 199) == 0);
            bus.in_valid       = ($urandom_range(0, 9) < 7);
            bus.in_data        = 4'($urandom);
            bus.in_parity_type = 1'($urandom);
            bus.out_ready      = ($urandom_range(0, 9) < 6);
            bus.inj_arm        = ($urandom_range(0, 15) == 0);
            bus.inj_pos        = 3'($urandom_range(0, 7));
            cyc();
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.inj_arm  = 1'b0;
        cyc();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
